// File: rtl/prt_pkg.sv
// Shared types and default sizing for the PRT read scheduler.
package prt_pkg;

    localparam int TABLE_SIZE = 8;
    localparam int INDEX_W    = 3;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        READ,
        DRAIN,
        DROP
    } sched_state_e;

    typedef struct packed {
        logic [INDEX_W-1:0] slot;
        logic               drop;
    } pend_entry_t;

endpackage

// File: rtl/prt_slot_fifo.sv
// Pending-slot queue: synchronous FIFO with count-based full/empty.
module prt_slot_fifo
    import prt_pkg::*;
#(
    parameter int DEPTH = TABLE_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  pend_entry_t i_push_entry,
    input  logic        i_pop,
    output pend_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    pend_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/prt_read_scheduler.sv
// Pops completed-frame reports and either streams the frame out of the PRT
// to egress (one byte in flight at a time) or invalidates the slot.
module prt_read_scheduler
    import prt_pkg::*;
#(
    parameter int TABLE_SIZE = prt_pkg::TABLE_SIZE,
    parameter int INDEX_W    = prt_pkg::INDEX_W,
    parameter int DATA_W     = prt_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done_valid,
    input  logic [INDEX_W-1:0] done_slot,
    input  logic               done_drop,
    output logic               done_ready,
    output logic               prt_start_rd,
    output logic [INDEX_W-1:0] prt_rd_slot,
    output logic               prt_rd_en,
    input  logic               prt_rd_valid,
    input  logic [DATA_W-1:0]  prt_rd_data,
    input  logic               prt_rd_last,
    output logic               prt_inval,
    output logic [INDEX_W-1:0] prt_inval_slot,
    output logic               eg_valid,
    output logic [DATA_W-1:0]  eg_data,
    output logic               eg_last,
    input  logic               eg_ready,
    output logic [15:0]        frames_sent,
    output logic [15:0]        frames_dropped
);

    sched_state_e       r_state;
    sched_state_e       w_next;
    pend_entry_t        w_head;
    pend_entry_t        w_push_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_start;
    logic               w_rd_en;
    logic               w_inval;
    logic               w_rd_ret;
    logic               w_eg_acc;
    logic [INDEX_W-1:0] r_slot;
    logic               r_outst;
    logic               r_eg_valid;
    logic [DATA_W-1:0]  r_eg_data;
    logic               r_eg_last;
    logic [15:0]        r_sent;
    logic [15:0]        r_dropped;

    assign w_push_entry = '{slot: done_slot, drop: done_drop};

    prt_slot_fifo #(.DEPTH(TABLE_SIZE)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (done_valid),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Returns arriving in any other state are stray and ignored.
    assign w_rd_ret = (r_state == READ) && prt_rd_valid;
    assign w_eg_acc = r_eg_valid && eg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_start = 1'b0;
        w_rd_en = 1'b0;
        w_inval = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = w_head.drop ? DROP : START;
                end
            end
            START: begin
                w_start = 1'b1;
                w_next  = READ;
            end
            READ: begin
                // Issue only if the egress register is free by the time the byte lands.
                w_rd_en = !r_outst && (!r_eg_valid || eg_ready);
                if (prt_rd_valid && prt_rd_last) w_next = DRAIN;
            end
            DRAIN: begin
                if (w_eg_acc) w_next = IDLE;
            end
            DROP: begin
                w_inval = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot     <= '0;
            r_outst    <= 1'b0;
            r_eg_valid <= 1'b0;
            r_eg_data  <= '0;
            r_eg_last  <= 1'b0;
            r_sent     <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_pop) r_slot <= w_head.slot;
            if (w_rd_en)       r_outst <= 1'b1;
            else if (w_rd_ret) r_outst <= 1'b0;
            if (w_rd_ret) begin
                r_eg_valid <= 1'b1;
                r_eg_data  <= prt_rd_data;
                r_eg_last  <= prt_rd_last;
            end else if (eg_ready) begin
                r_eg_valid <= 1'b0;
            end
            if (r_state == DRAIN && w_eg_acc) r_sent    <= r_sent + 16'd1;
            if (r_state == DROP)              r_dropped <= r_dropped + 16'd1;
        end
    end

    assign done_ready     = !w_full;
    assign prt_start_rd   = w_start;
    assign prt_rd_slot    = r_slot;
    assign prt_rd_en      = w_rd_en;
    assign prt_inval      = w_inval;
    assign prt_inval_slot = r_slot;
    assign eg_valid       = r_eg_valid;
    assign eg_data        = r_eg_data;
    assign eg_last        = r_eg_last;
    assign frames_sent    = r_sent;
    assign frames_dropped = r_dropped;

endmodule
